uart_rx: RTL and testbench

Asynchronous serial receiver for the UART path, 8N1 framing. Consumes the 16x-oversampled receive enable produced by the baud generator, recovers bytes from the synchronised serial input, and presents them to the bus interface with a valid/acknowledge handshake. It also reports framing and overrun errors. One instance sits beside the transmitter, and both share one baud generator.

---
 rtl/uart_rx.sv | 155 +++++++++++++++
 tb/tb_uart_rx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx -- 8N1 asynchronous serial receiver, 16x oversampled.
//
// Recovers bytes from the serial line using the baud generator's 16x
// receive enable and hands each byte to the bus side with a
// valid/acknowledge handshake. Framing and overrun errors are also reported.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   receive_baud single-cycle enable, 16 per bit period
//   rxd          serial line (idle high, asynchronous to clk)
//   rx_ack       single-cycle pulse: consumer has read rx_data
//   rx_data      last accepted byte (LSB received first)
//   rx_valid     a byte is waiting; held until rx_ack
//   frame_error  the byte in rx_data had a low stop bit
//   overrun      sticky: a byte was dropped while rx_valid was set
//   rx_busy      receiver is inside a frame (state != IDLE)
module uart_rx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       receive_baud,
  input  logic       rxd,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_error,
  output logic       overrun,
  output logic       rx_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t     state, state_nxt;
  logic       rxd_meta, rxs;
  logic [3:0] tc, tc_nxt;
  logic [2:0] bc, bc_nxt;
  logic [7:0] shift, shift_nxt;
  logic       stop_sample;
  logic       complete;

  // Two-flop synchroniser; resets to the idle line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta <= 1'b1;
      rxs      <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxs      <= rxd_meta;
    end
  end

  // State register: advances only on receive ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      tc    <= '0;
      bc    <= '0;
      shift <= '0;
    end else if (receive_baud) begin
      state <= state_nxt;
      tc    <= tc_nxt;
      bc    <= bc_nxt;
      shift <= shift_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt   = state;
    tc_nxt      = tc;
    bc_nxt      = bc;
    shift_nxt   = shift;
    stop_sample = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rxs) begin
          state_nxt = START;
          tc_nxt    = '0;
        end
      end
      START: begin
        if (tc == 4'd7) begin
          tc_nxt = '0;
          if (!rxs) begin
            state_nxt = DATA;
            bc_nxt    = '0;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          tc_nxt = tc + 4'd1;
        end
      end
      DATA: begin
        if (tc == 4'd15) begin
          shift_nxt = {rxs, shift[7:1]};
          tc_nxt    = '0;
          if (bc == 3'd7) begin
            state_nxt = STOP;
          end else begin
            bc_nxt = bc + 3'd1;
          end
        end else begin
          tc_nxt = tc + 4'd1;
        end
      end
      STOP: begin
        if (tc == 4'd15) begin
          stop_sample = 1'b1;
          state_nxt   = IDLE;
          tc_nxt      = '0;
        end else begin
          tc_nxt = tc + 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    rx_busy  = (state != IDLE);
    complete = receive_baud & stop_sample;
  end

  // Handshake registers. A completion takes priority over a coincident
  // rx_ack: the ack frees the slot, so the new byte is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else if (complete) begin
      if (!rx_valid || rx_ack) begin
        rx_data     <= shift;
        rx_valid    <= 1'b1;
        frame_error <= ~rxs;
        overrun     <= 1'b0;
      end else begin
        overrun <= 1'b1;
      end
    end else if (rx_ack) begin
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- self-checking bench for uart_rx.
// Drives 8N1 frames (16 ticks per bit) and compares the handshake outputs
// against a transaction-level model of the receiver's delivery rules.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       receive_baud = 1'b0;
  logic       rxd = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_error;
  logic       overrun;
  logic       rx_busy;

  uart_rx dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .receive_baud (receive_baud),
    .rxd          (rxd),
    .rx_ack       (rx_ack),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .frame_error  (frame_error),
    .overrun      (overrun),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned gap      = 4;   // clk cycles per tick

  // Reference model of what the consumer should see.
  logic [7:0] m_data  = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_fe    = 1'b0;
  logic       m_ovr   = 1'b0;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One tick period: rxd has settled through the synchroniser before the
  // enable cycle at the end of the period.
  task automatic do_tick(input bit ack);
    repeat (gap - 1) cyc();
    receive_baud = 1'b1;
    rx_ack       = ack;
    cyc();
    receive_baud = 1'b0;
    rx_ack       = 1'b0;
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    for (int i = 0; i < n; i++) do_tick(1'b0);
  endtask

  task automatic model_ack();
    m_valid = 1'b0;
    m_fe    = 1'b0;
    m_ovr   = 1'b0;
  endtask

  task automatic model_reset();
    m_data = 8'h00;
    model_ack();
  endtask

  task automatic model_complete(input logic [7:0] b, input bit stop, input bit ack_same);
    if (!m_valid || ack_same) begin
      m_data  = b;
      m_valid = 1'b1;
      m_fe    = ~stop;
      m_ovr   = 1'b0;
    end else begin
      m_ovr = 1'b1;
    end
  endtask

  task automatic pulse_ack();
    rx_ack = 1'b1;
    cyc();
    rx_ack = 1'b0;
    model_ack();
  endtask

  task automatic check_outputs(input string tag, input logic exp_busy);
    check_eq($sformatf("%s.data", tag),  rx_data, m_data);
    check_eq($sformatf("%s.valid", tag), {7'd0, rx_valid}, {7'd0, m_valid});
    check_eq($sformatf("%s.fe", tag),    {7'd0, frame_error}, {7'd0, m_fe});
    check_eq($sformatf("%s.ovr", tag),   {7'd0, overrun}, {7'd0, m_ovr});
    check_eq($sformatf("%s.busy", tag),  {7'd0, rx_busy}, {7'd0, exp_busy});
  endtask

  // ack_mode: 0 none, 1 rx_ack on the stop-sample tick, 2 rx_ack one cycle
  // after the byte is delivered.
  task automatic send_frame(input logic [7:0] b, input bit stop, input int ack_mode);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = bits[i];
      for (int t = 0; t < 16; t++) begin
        if (i == 9 && t == 8) begin
          do_tick(ack_mode == 1);
          model_complete(b, stop, ack_mode == 1);
          check_eq("busy_fall", {7'd0, rx_busy}, 8'd0);
          if (ack_mode == 2) begin
            check_eq("valid_pre_ack", {7'd0, rx_valid}, 8'd1);
            check_eq("data_pre_ack", rx_data, m_data);
            pulse_ack();
          end
        end else begin
          do_tick(1'b0);
        end
        if (i == 0 && t == 0) check_eq("busy_rise", {7'd0, rx_busy}, 8'd1);
      end
    end
    rxd = 1'b1;
  endtask

  initial begin
    logic [7:0] partial;
    logic [7:0] rb;
    bit         rstop;
    int         rmode;

    // Reset
    #2 rst_n = 1'b0;
    repeat (3) cyc();
    check_outputs("reset", 1'b0);
    rst_n = 1'b1;
    idle(4);
    check_outputs("post_reset", 1'b0);

    // Clean byte
    send_frame(8'hA5, 1'b1, 0);
    check_outputs("a5", 1'b0);
    pulse_ack();
    check_outputs("a5_ack", 1'b0);

    // Framing error: held-low stop re-enters START
    send_frame(8'h3C, 1'b0, 0);
    check_outputs("fe", 1'b1);
    idle(10);
    check_outputs("fe_idle", 1'b0);
    pulse_ack();
    check_outputs("fe_ack", 1'b0);
    send_frame(8'h55, 1'b1, 0);
    check_outputs("x55", 1'b0);
    pulse_ack();

    // Glitch: 5 ticks low, rejected at the mid-bit sample
    rxd = 1'b0;
    for (int t = 0; t < 5; t++) do_tick(1'b0);
    check_eq("glitch.busy", {7'd0, rx_busy}, 8'd1);
    rxd = 1'b1;
    do_tick(1'b0);
    do_tick(1'b0);
    do_tick(1'b0);
    check_eq("glitch.busy7", {7'd0, rx_busy}, 8'd1);
    do_tick(1'b0);
    check_outputs("glitch_end", 1'b0);
    idle(2);

    // Overrun, then ack coinciding with completion
    send_frame(8'h11, 1'b1, 0);
    send_frame(8'h22, 1'b1, 0);
    check_outputs("overrun", 1'b0);
    send_frame(8'h33, 1'b1, 1);
    check_outputs("ack_same", 1'b0);

    // Reset in the middle of 0xF0 (after bit 3), with a byte pending
    partial = 8'hF0;
    rxd = 1'b0;
    for (int t = 0; t < 16; t++) do_tick(1'b0);
    for (int i = 0; i < 4; i++) begin
      rxd = partial[i];
      for (int t = 0; t < 16; t++) do_tick(1'b0);
    end
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("mid_reset", 1'b0);
    rxd = 1'b1;
    repeat (2) cyc();
    rst_n = 1'b1;
    idle(4);
    check_outputs("after_reset", 1'b0);
    send_frame(8'h81, 1'b1, 0);
    check_outputs("x81", 1'b0);
    pulse_ack();

    // Boundary values back to back, acked one cycle after delivery
    send_frame(8'h00, 1'b1, 2);
    check_outputs("x00", 1'b0);
    send_frame(8'hFF, 1'b1, 2);
    check_outputs("xFF", 1'b0);

    // Randomised frames with varying tick spacing and ack behaviour
    for (int n = 0; n < 25; n++) begin
      gap   = $urandom_range(3, 6);
      rb    = 8'($urandom);
      rstop = ($urandom_range(0, 7) != 0);
      rmode = int'($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) pulse_ack();
      send_frame(rb, rstop, rmode);
      check_outputs($sformatf("rnd%0d", n), ~rstop);
      if (!rstop) idle(10);
      else idle(int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
